// File: rtl/cw_word_loader.sv
// Byte-to-codeword packer feeding the 20-8 constant-weight decoder input FIFO.
// Define CW_WEIGHT_CHECK_EN to add the sticky weight_err popcount check.
module cw_word_loader #(
   parameter int CW_W   = 20,
   parameter int NUM_CW = 10,
   parameter int CW_WT  = 8
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            msg_start,
   input  logic [7:0]      byte_in,
   input  logic            byte_valid,
   output logic            byte_ready,
   input  logic            fifo_full,
   output logic [CW_W-1:0] cw_word,
   output logic            cw_wr_en,
   output logic            dec_start,
`ifdef CW_WEIGHT_CHECK_EN
   output logic            weight_err,
`endif
   output logic            load_done
);

   localparam int ACC_W = CW_W + 7;
   localparam int BC_W  = $clog2(ACC_W + 1);
   localparam int WC_W  = $clog2(NUM_CW + 1);

   localparam logic [BC_W-1:0] CW_W_BC   = BC_W'(CW_W);
   localparam logic [BC_W-1:0] BYTE_BC   = BC_W'(8);
   localparam logic [WC_W-1:0] NUM_CW_WC = WC_W'(NUM_CW);
   localparam logic [WC_W-1:0] ONE_WC    = WC_W'(1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [BC_W-1:0]  bcnt, bcnt_n;
   logic [WC_W-1:0]  wcnt, wcnt_n;
   logic [CW_W-1:0]  cw_q;
   logic             dec_q;
   logic             ready_c, wr_c, done_c;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_n = state;
      acc_n   = acc;
      bcnt_n  = bcnt;
      wcnt_n  = wcnt;
      ready_c = 1'b0;
      wr_c    = 1'b0;
      done_c  = 1'b0;
      unique case (state)
         IDLE: begin
            if (msg_start) begin
               state_n = FILL;
               acc_n   = '0;
               bcnt_n  = '0;
               wcnt_n  = '0;
            end
         end
         FILL: begin
            if (bcnt >= CW_W_BC) begin
               state_n = WRITE;
            end else begin
               ready_c = 1'b1;
               if (byte_valid) begin
                  acc_n  = acc | (ACC_W'(byte_in) << bcnt);
                  bcnt_n = bcnt + BYTE_BC;
               end
            end
         end
         WRITE: begin
            if (!fifo_full) begin
               wr_c    = 1'b1;
               acc_n   = acc >> CW_W;
               bcnt_n  = bcnt - CW_W_BC;
               wcnt_n  = wcnt + ONE_WC;
               state_n = (wcnt_n == NUM_CW_WC) ? DONE : FILL;
            end
         end
         DONE: begin
            done_c  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_b) begin
         state <= IDLE;
         acc   <= '0;
         bcnt  <= '0;
         wcnt  <= '0;
         cw_q  <= '0;
         dec_q <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         bcnt  <= bcnt_n;
         wcnt  <= wcnt_n;
         if (wr_c) cw_q <= acc[CW_W-1:0];
         dec_q <= wr_c && (wcnt == '0);
      end
   end

`ifdef CW_WEIGHT_CHECK_EN
   logic werr_q;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         werr_q <= 1'b0;
      end else if (state == IDLE && msg_start) begin
         werr_q <= 1'b0;
      end else if (wr_c && ($countones(acc[CW_W-1:0]) != CW_WT)) begin
         werr_q <= 1'b1;
      end
   end

   assign weight_err = rst_b & werr_q;
`endif

   // Outputs are forced low while rst_b is asserted, before the clearing edge arrives.
   assign byte_ready = rst_b & ready_c;
   assign cw_wr_en   = rst_b & wr_c;
   assign cw_word    = !rst_b ? '0 : (wr_c ? acc[CW_W-1:0] : cw_q);
   assign dec_start  = rst_b & dec_q;
   assign load_done  = rst_b & done_c;

endmodule

// File: tb/tb_cw_word_loader.sv
// Self-checking bench for cw_word_loader: randomized byte streams against a bit-stream model.
// Weight-check scenarios run only when CW_WEIGHT_CHECK_EN is defined.
module tb_cw_word_loader;

   localparam int CW_W   = 20;
   localparam int NUM_CW = 10;
   localparam int CW_WT  = 8;
   localparam int NBYTES = (NUM_CW * CW_W + 7) / 8;
   localparam int BUDGET = 800;

   logic            clk = 1'b0;
   logic            rst_b;
   logic            msg_start;
   logic [7:0]      byte_in;
   logic            byte_valid;
   logic            byte_ready;
   logic            fifo_full;
   logic [CW_W-1:0] cw_word;
   logic            cw_wr_en;
   logic            dec_start;
   logic            load_done;
`ifdef CW_WEIGHT_CHECK_EN
   logic            weight_err;
`endif

   int checks   = 0;
   int failures = 0;

   // Scenario configuration consumed by run_message
   logic [7:0]      msg_bytes [NBYTES];
   int              valid_mode;   // 0 always, 1 alternate, 2 random
   int              full_mode;    // 0 never, 1 stall on one word, 2 random
   int              stall_word;
   int              stall_len;
   int              restart_cyc;  // cycle of a redundant msg_start, -1 for none
   logic [CW_W-1:0] got_words [NUM_CW];

   cw_word_loader #(.CW_W(CW_W), .NUM_CW(NUM_CW), .CW_WT(CW_WT)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .msg_start  (msg_start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .fifo_full  (fifo_full),
      .cw_word    (cw_word),
      .cw_wr_en   (cw_wr_en),
      .dec_start  (dec_start),
`ifdef CW_WEIGHT_CHECK_EN
      .weight_err (weight_err),
`endif
      .load_done  (load_done)
   );

   always #5 clk = ~clk;

   // Word k is simply bits [k*CW_W +: CW_W] of the LSB-first message bit stream.
   function automatic logic [CW_W-1:0] model_word(input int k);
      logic [CW_W-1:0] w;
      int idx;
      w = '0;
      for (int b = 0; b < CW_W; b++) begin
         idx  = k * CW_W + b;
         w[b] = msg_bytes[idx / 8][idx % 8];
      end
      return w;
   endfunction

   task automatic set_cfg(input int vm, input int fm, input int sw, input int sl, input int rs);
      valid_mode  = vm;
      full_mode   = fm;
      stall_word  = sw;
      stall_len   = sl;
      restart_cyc = rs;
   endtask

   task automatic run_message(input string tag);
      int              cyc, nb, nw, held, lb, earliest;
      int              first_wr, last_wr, dec_cnt, dec_cyc, done_cnt, done_cyc, end_cyc, stall_left;
      int              xfer_cyc [NBYTES];
      bit              full_hist [BUDGET];
      bit              exp_ready;
      logic [CW_W-1:0] expw;
`ifdef CW_WEIGHT_CHECK_EN
      bit              werr_exp;
      werr_exp = 1'b0;
`endif
      @(negedge clk);
      msg_start  = 1'b1;
      byte_valid = 1'b0;
      fifo_full  = 1'b0;
      @(negedge clk);
      msg_start  = 1'b0;
      cyc = 0; nb = 0; nw = 0; first_wr = -1; last_wr = -1;
      dec_cnt = 0; dec_cyc = -1; done_cnt = 0; done_cyc = -1; end_cyc = -1;
      stall_left = stall_len;
      while (cyc < BUDGET && (end_cyc < 0 || cyc <= end_cyc)) begin
         msg_start = (cyc == restart_cyc);
         case (valid_mode)
            0:       byte_valid = 1'b1;
            1:       byte_valid = (cyc % 2 == 0);
            default: byte_valid = 1'($urandom_range(0, 1));
         endcase
         byte_in   = (nb < NBYTES) ? msg_bytes[nb] : 8'($urandom);
         fifo_full = 1'b0;
         if (full_mode == 2) begin
            fifo_full = ($urandom_range(0, 3) == 0);
         end else if (full_mode == 1 && nw == stall_word && 8 * nb >= CW_W * (nw + 1) && stall_left > 0) begin
            fifo_full = 1'b1;
            stall_left--;
         end
         full_hist[cyc] = fifo_full;
         #1;
         held      = 8 * nb - CW_W * nw;
         exp_ready = (nw < NUM_CW) && (held < CW_W);
         checks++;
         if (byte_ready !== exp_ready) begin
            failures++;
            $display("FAIL %s byte_ready cyc=%0d got=%b exp=%b", tag, cyc, byte_ready, exp_ready);
         end
`ifdef CW_WEIGHT_CHECK_EN
         checks++;
         if (weight_err !== werr_exp) begin
            failures++;
            $display("FAIL %s weight_err cyc=%0d got=%b exp=%b", tag, cyc, weight_err, werr_exp);
         end
`endif
         if (byte_valid && byte_ready) begin
            if (nb < NBYTES) xfer_cyc[nb] = cyc;
            nb++;
         end
         if (cw_wr_en) begin
            checks++;
            if (nw >= NUM_CW || fifo_full) begin
               failures++;
               $display("FAIL %s unexpected_write cyc=%0d words=%0d fifo_full=%b", tag, cyc, nw, fifo_full);
            end else begin
               expw = model_word(nw);
               checks++;
               if (cw_word !== expw) begin
                  failures++;
                  $display("FAIL %s word%0d got=%h exp=%h", tag, nw, cw_word, expw);
               end
               lb = (CW_W * (nw + 1) + 7) / 8 - 1;
               checks++;
               if (lb >= nb) begin
                  failures++;
                  $display("FAIL %s early_write word%0d got_bytes=%0d need=%0d", tag, nw, nb, lb + 1);
               end else begin
                  earliest = xfer_cyc[lb] + 2;
                  while (earliest < cyc && full_hist[earliest]) earliest++;
                  if (cyc != earliest) begin
                     failures++;
                     $display("FAIL %s latency word%0d got_cyc=%0d exp_cyc=%0d", tag, nw, cyc, earliest);
                  end
               end
`ifdef CW_WEIGHT_CHECK_EN
               if ($countones(expw) != CW_WT) werr_exp = 1'b1;
`endif
               got_words[nw] = cw_word;
               if (first_wr < 0) first_wr = cyc;
               last_wr = cyc;
               nw++;
            end
         end else if (nw > 0) begin
            expw = model_word(nw - 1);
            checks++;
            if (cw_word !== expw) begin
               failures++;
               $display("FAIL %s cw_word_hold cyc=%0d got=%h exp=%h", tag, cyc, cw_word, expw);
            end
         end
         if (dec_start) begin
            dec_cnt++;
            if (dec_cyc < 0) dec_cyc = cyc;
         end
         if (load_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            if (end_cyc < 0) end_cyc = cyc + 4;
         end
         cyc++;
         @(negedge clk);
      end
      byte_valid = 1'b0;
      msg_start  = 1'b0;
      fifo_full  = 1'b0;
      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL %s timeout got_load_done=0 exp=1 within %0d cycles", tag, BUDGET);
      end
      checks++;
      if (nw != NUM_CW || nb != NBYTES) begin
         failures++;
         $display("FAIL %s counts got_words=%0d got_bytes=%0d exp_words=%0d exp_bytes=%0d", tag, nw, nb, NUM_CW, NBYTES);
      end
      checks++;
      if (dec_cnt != 1 || dec_cyc != first_wr + 1) begin
         failures++;
         $display("FAIL %s dec_start got_cnt=%0d got_cyc=%0d exp_cnt=1 exp_cyc=%0d", tag, dec_cnt, dec_cyc, first_wr + 1);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_wr + 1) begin
         failures++;
         $display("FAIL %s load_done got_cnt=%0d got_cyc=%0d exp_cnt=1 exp_cyc=%0d", tag, done_cnt, done_cyc, last_wr + 1);
      end
   endtask

   task automatic test_reset();
      rst_b      = 1'b0;
      byte_valid = 1'b1;
      msg_start  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({byte_ready, cw_wr_en, dec_start, load_done} !== 4'b0 || cw_word !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b%b%b%b word=%h exp=0000 word=0", byte_ready, cw_wr_en, dec_start, load_done, cw_word);
      end
      rst_b = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (byte_ready !== 1'b0 || cw_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL idle_outputs got_ready=%b got_wr=%b exp=0 0", byte_ready, cw_wr_en);
      end
      byte_valid = 1'b0;
   endtask

   task automatic test_basic();
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'(i);
      set_cfg(0, 0, 0, 0, -1);
      run_message("basic");
      checks++;
      if (got_words[0] !== 20'h20100 || got_words[1] !== 20'h04030 || got_words[2] !== 20'h70605) begin
         failures++;
         $display("FAIL basic_literals got=%h %h %h exp=20100 04030 70605", got_words[0], got_words[1], got_words[2]);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'(i);
      set_cfg(0, 1, 1, 5, -1);
      run_message("backpressure");
      checks++;
      if (got_words[1] !== 20'h04030) begin
         failures++;
         $display("FAIL backpressure_word1 got=%h exp=04030", got_words[1]);
      end
   endtask

   task automatic test_sparse();
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'(i);
      set_cfg(1, 0, 0, 0, -1);
      run_message("sparse");
   endtask

   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'($urandom);
      @(negedge clk);
      msg_start = 1'b1;
      @(negedge clk);
      msg_start  = 1'b0;
      byte_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && n < 12; c++) begin
         byte_in = msg_bytes[n];
         #1;
         if (byte_ready) n++;
         @(negedge clk);
      end
      checks++;
      if (n != 12) begin
         failures++;
         $display("FAIL reset_mid_prefill got_bytes=%0d exp=12", n);
      end
      rst_b = 1'b0;
      #1;
      checks++;
      if ({byte_ready, cw_wr_en, dec_start, load_done} !== 4'b0 || cw_word !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs got=%b%b%b%b word=%h exp=0000 word=0", byte_ready, cw_wr_en, dec_start, load_done, cw_word);
      end
      @(negedge clk);
      rst_b      = 1'b1;
      byte_valid = 1'b0;
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'($urandom);
      set_cfg(0, 0, 0, 0, -1);
      run_message("after_reset");
   endtask

   task automatic test_ignored_start();
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'($urandom);
      set_cfg(0, 0, 0, 0, 7);
      run_message("restart_fill");
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'($urandom);
      set_cfg(1, 1, 3, 4, 24);
      run_message("restart_stall");
   endtask

   task automatic test_random();
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'($urandom);
         set_cfg(2, 2, 0, 0, -1);
         run_message($sformatf("random%0d", m));
      end
   endtask

`ifdef CW_WEIGHT_CHECK_EN
   task automatic test_weight();
      int idx;
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = 8'(i);
      set_cfg(0, 0, 0, 0, -1);
      run_message("weight_bad");
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (weight_err !== 1'b1) begin
         failures++;
         $display("FAIL weight_sticky got=%b exp=1", weight_err);
      end
      for (int i = 0; i < NBYTES; i++) msg_bytes[i] = '0;
      for (int k = 0; k < NUM_CW; k++) begin
         for (int b = 0; b < 8; b++) begin
            idx = k * CW_W + b;
            msg_bytes[idx / 8][idx % 8] = 1'b1;
         end
      end
      run_message("weight_good");
   endtask
`endif

   initial begin
      rst_b      = 1'b0;
      msg_start  = 1'b0;
      byte_valid = 1'b0;
      byte_in    = '0;
      fifo_full  = 1'b0;
      set_cfg(0, 0, 0, 0, -1);
      test_reset();
      test_basic();
      test_backpressure();
      test_sparse();
      test_reset_mid();
      test_ignored_start();
      test_random();
`ifdef CW_WEIGHT_CHECK_EN
      test_weight();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cw_word_loader.md
Name: cw_word_loader

Overview:
Upstream stage of the 20-8 constant-weight decoder. It accepts a byte stream over a valid/ready handshake and packs the bits LSB-first into CW_W-bit codewords. Each completed codeword is written into the decoder's input FIFO, honouring the FIFO full flag. The block pulses the decoder start after the first word of a message is in the FIFO, and signals completion after NUM_CW words.

Parameters:
CW_W, 20, codeword width in bits (FIFO data width)
NUM_CW, 10, codewords per message
CW_WT, 8, expected codeword Hamming weight (used only by the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_b  input  1  synchronous active-low reset
msg_start  input  1  one-cycle request to begin loading a message; honoured only in IDLE
byte_in  input  8  message byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts byte_in this cycle
fifo_full  input  1  decoder FIFO full flag
cw_word  output  CW_W  codeword to FIFO din
cw_wr_en  output  1  FIFO write strobe, one cycle per codeword
dec_start  output  1  one-cycle start pulse to the decoder
load_done  output  1  one-cycle pulse after the last codeword is written

Behaviour:
- Reset: all state is cleared synchronously when rst_b=0 at a clock edge, including mid-message. Output values under reset: byte_ready=0, cw_word=0, cw_wr_en=0, dec_start=0, load_done=0. State goes to IDLE; the accumulator, bit count (bcnt) and word count (wcnt) go to 0; any partial word is discarded.
- State machine: IDLE, FILL, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - msg_start=1 moves to FILL and clears the accumulator, bcnt and wcnt.
  - msg_start in any other state is ignored.
- FILL:
  - byte_ready=1 while bcnt<CW_W.
  - On a transfer (byte_valid and byte_ready), the accumulator gets acc | (byte_in<<bcnt) and bcnt increases by 8.
  - When bcnt>=CW_W, go to WRITE; byte_ready is 0 from that cycle on.
  - Accumulator width is CW_W+7 bits; bcnt never exceeds CW_W+7.
- WRITE:
  - byte_ready=0.
  - If fifo_full=0: cw_wr_en=1 for exactly one cycle, with cw_word=acc[CW_W-1:0] in the same cycle. Then acc is shifted right by CW_W, bcnt decreases by CW_W and wcnt increments.
  - If fifo_full=1: stall in WRITE. cw_wr_en=0 and cw_word holds its value.
  - After the write: if wcnt reaches NUM_CW go to DONE, else go to FILL.
  - If the residual bcnt is still >=CW_W, FILL immediately returns to WRITE on the next cycle.
- DONE:
  - load_done=1 for one cycle, then return to IDLE.
  - Residual accumulator bits are discarded.
- Byte count: a message is exactly ceil(NUM_CW*CW_W/8) bytes, which is 25 bytes for the defaults. Extra bytes are not accepted because byte_ready=0 outside FILL.
- dec_start: one-cycle pulse in the cycle after the first cw_wr_en of a message, so the FIFO is non-empty when the decoder starts. It pulses exactly once per message.
- cw_word holds its last written value between writes. It is not a valid qualifier; cw_wr_en is.
- Latency: a word completed by a byte transfer at cycle t is written at cycle t+2 if fifo_full=0 (FILL to WRITE transition, then the write).
- Simultaneous events: byte acceptance and FIFO write never occur in the same cycle. fifo_full rising in the WRITE cycle suppresses the write and nothing is lost.

Optional Feature:
CW_WEIGHT_CHECK_EN
- Defined:
  - Adds output weight_err (1 bit, reset 0).
  - In each write cycle, the popcount of the written word is compared with CW_WT; on a mismatch, weight_err is set the following cycle.
  - weight_err is sticky until the next accepted msg_start or reset.
  - The word is still written.
- Undefined: no port and no popcount logic; behaviour is otherwise identical.

Test Plan:
- Basic packing: msg_start, then bytes 0x00..0x18 with byte_valid always 1 and fifo_full=0. Required: exactly 10 cw_wr_en pulses; word0=0x20100, word1=0x04030, word2=0x70605; dec_start one cycle after word0; load_done one cycle after word9; byte_ready=0 after 25 bytes.
- FIFO backpressure: same stream, fifo_full=1 for 5 cycles while word1 is pending. Required: no cw_wr_en and byte_ready=0 during the stall; word1=0x04030 written in the first cycle fifo_full=0; final word sequence unchanged.
- Sparse valid: byte_valid toggles 1/0 every cycle. Required: identical word values and count; no byte lost or duplicated.
- Reset mid-message: rst_b=0 for 1 cycle after 12 bytes, then a new message. Required: all outputs 0 during reset and the new message's words are correct with no stale bits.
- Ignored start: msg_start pulsed again mid-message. Required: no effect on bcnt, wcnt or output words; dec_start pulses only once.
- Weight check (macro defined): word 0x000FF produces no error; word 0x20100 sets weight_err, which stays set until the next msg_start.
